// File: rtl/toy_dtcm_resp_queue.sv
`default_nettype none
// ============================================================================
// Module   : toy_dtcm_resp_queue
// Purpose  : DTCM load-response tracker. Captures the load sideband in a
//            single pending stage, takes the SRAM read word one cycle after
//            acceptance, aligns (and optionally size/sign-extends) it, and
//            buffers the result in a DEPTH-entry FIFO toward writeback.
//            cancel_en flushes pending and buffered loads. The int/fp wakeup
//            fires only on the cycle a result leaves the FIFO.
// Macro    : TOY_DTCM_RESP_SEXT_EN - when defined, the result is masked to
//            8<<size bits and sign/zero extended. When undefined, the result
//            is the shifted word only.
// Ports    : clk, rst (async, active-high)
//            req_vld/req_rdy, req_phy_id, req_int, req_fp, req_off,
//            req_size, req_signed           - load request sideband
//            mem_vld, mem_data              - SRAM read return
//            cancel_en                      - pipeline flush
//            resp_vld/resp_rdy, resp_data, resp_phy_id - writeback result
//            fwd_int_en, fwd_fp_en, fwd_phy_id         - wakeup
// Revision : 1.0 - initial release
// ============================================================================
module toy_dtcm_resp_queue #(
  parameter int DATA_W   = 64,
  parameter int PHY_ID_W = 6,
  parameter int DEPTH    = 4,
  parameter int OFF_W    = $clog2(DATA_W / 8)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_vld,
  output logic                req_rdy,
  input  logic [PHY_ID_W-1:0] req_phy_id,
  input  logic                req_int,
  input  logic                req_fp,
  input  logic [OFF_W-1:0]    req_off,
  input  logic [1:0]          req_size,
  input  logic                req_signed,
  input  logic                mem_vld,
  input  logic [DATA_W-1:0]   mem_data,
  input  logic                cancel_en,
  output logic                resp_vld,
  input  logic                resp_rdy,
  output logic [DATA_W-1:0]   resp_data,
  output logic [PHY_ID_W-1:0] resp_phy_id,
  output logic                fwd_int_en,
  output logic                fwd_fp_en,
  output logic [PHY_ID_W-1:0] fwd_phy_id
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Pending stage: sideband of the load whose SRAM data arrives next cycle
  logic                pend_vld_q, pend_vld_d;
  logic [PHY_ID_W-1:0] pend_id_q,  pend_id_d;
  logic                pend_int_q, pend_int_d;
  logic                pend_fp_q,  pend_fp_d;
  logic [OFF_W-1:0]    pend_off_q, pend_off_d;
`ifdef TOY_DTCM_RESP_SEXT_EN
  logic [1:0]          pend_size_q,   pend_size_d;
  logic                pend_signed_q, pend_signed_d;
`endif

  // FIFO control
  logic [PTR_W-1:0]    wr_ptr_q,   wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q,   rd_ptr_d;
  logic [CNT_W-1:0]    fifo_cnt_q, fifo_cnt_d;

  // FIFO storage (not reset; outputs masked while empty)
  logic [DATA_W-1:0]   fifo_data_q [DEPTH];
  logic [PHY_ID_W-1:0] fifo_id_q   [DEPTH];
  logic                fifo_int_q  [DEPTH];
  logic                fifo_fp_q   [DEPTH];

  logic                accept;
  logic                push;
  logic                pop;
  logic [DATA_W-1:0]   aligned;
  logic [DATA_W-1:0]   ext_data;

  // Credit counts the pending load too, so a slot is always free for it
  assign req_rdy  = (CNT_W'(pend_vld_q) + fifo_cnt_q) < CNT_W'(DEPTH);
  assign accept   = req_vld & req_rdy & ~cancel_en;
  assign push     = mem_vld & pend_vld_q & ~cancel_en;
  assign resp_vld = (fifo_cnt_q != '0);
  // A pop coinciding with cancel is void: the flush wins
  assign pop      = resp_vld & resp_rdy & ~cancel_en;

  assign aligned  = mem_data >> {pend_off_q, 3'b000};

`ifdef TOY_DTCM_RESP_SEXT_EN
  logic [31:0]       keep_bits;
  logic [DATA_W-1:0] keep_mask;
  logic [DATA_W-1:0] top_bit;
  logic              fill;

  always_comb begin
    keep_bits = 32'd8 << pend_size_q;
    // Shifting by >= DATA_W yields zero, so wide sizes keep every bit
    keep_mask = ~({DATA_W{1'b1}} << keep_bits);
    top_bit   = keep_mask & ~(keep_mask >> 1);
    fill      = pend_signed_q & (|(aligned & top_bit));
    ext_data  = fill ? (aligned | ~keep_mask) : (aligned & keep_mask);
    if (pend_size_q == 2'd3) begin
      ext_data = aligned;
    end
  end
`else
  logic unused_sext;
  assign unused_sext = ^{req_size, req_signed};
  assign ext_data    = aligned;
`endif

  always_comb begin
    pend_vld_d = pend_vld_q;
    pend_id_d  = pend_id_q;
    pend_int_d = pend_int_q;
    pend_fp_d  = pend_fp_q;
    pend_off_d = pend_off_q;
`ifdef TOY_DTCM_RESP_SEXT_EN
    pend_size_d   = pend_size_q;
    pend_signed_d = pend_signed_q;
`endif
    if (cancel_en) begin
      pend_vld_d = 1'b0;
    end else if (accept) begin
      pend_vld_d = 1'b1;
      pend_id_d  = req_phy_id;
      pend_int_d = req_int;
      pend_fp_d  = req_fp;
      pend_off_d = req_off;
`ifdef TOY_DTCM_RESP_SEXT_EN
      pend_size_d   = req_size;
      pend_signed_d = req_signed;
`endif
    end else if (push) begin
      pend_vld_d = 1'b0;
    end

    wr_ptr_d   = wr_ptr_q + PTR_W'(push);
    rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
    fifo_cnt_d = fifo_cnt_q + CNT_W'(push) - CNT_W'(pop);
    if (cancel_en) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      fifo_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_vld_q <= 1'b0;
      pend_id_q  <= '0;
      pend_int_q <= 1'b0;
      pend_fp_q  <= 1'b0;
      pend_off_q <= '0;
`ifdef TOY_DTCM_RESP_SEXT_EN
      pend_size_q   <= '0;
      pend_signed_q <= 1'b0;
`endif
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      pend_vld_q <= pend_vld_d;
      pend_id_q  <= pend_id_d;
      pend_int_q <= pend_int_d;
      pend_fp_q  <= pend_fp_d;
      pend_off_q <= pend_off_d;
`ifdef TOY_DTCM_RESP_SEXT_EN
      pend_size_q   <= pend_size_d;
      pend_signed_q <= pend_signed_d;
`endif
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fifo_cnt_q <= fifo_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data_q[wr_ptr_q] <= ext_data;
      fifo_id_q[wr_ptr_q]   <= pend_id_q;
      fifo_int_q[wr_ptr_q]  <= pend_int_q;
      fifo_fp_q[wr_ptr_q]   <= pend_fp_q;
    end
  end

  // Head outputs; masked to zero while the FIFO is empty
  assign resp_data   = resp_vld ? fifo_data_q[rd_ptr_q] : '0;
  assign resp_phy_id = resp_vld ? fifo_id_q[rd_ptr_q]   : '0;
  assign fwd_phy_id  = resp_phy_id;
  assign fwd_int_en  = resp_vld & resp_rdy & fifo_int_q[rd_ptr_q];
  assign fwd_fp_en   = resp_vld & resp_rdy & fifo_fp_q[rd_ptr_q];

endmodule
`default_nettype wire

// File: tb/tb_toy_dtcm_resp_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_toy_dtcm_resp_queue
// Purpose  : Scoreboard bench for toy_dtcm_resp_queue. The driver acts as the
//            SRAM, answering each accepted load one cycle later and pushing
//            the reference result; a negedge monitor compares every pop.
// Revision : 1.0 - initial release
// ============================================================================
module tb_toy_dtcm_resp_queue;

  localparam int DATA_W   = 64;
  localparam int PHY_ID_W = 6;
  localparam int DEPTH    = 4;
  localparam int OFF_W    = 3;

  logic                clk = 1'b0;
  logic                rst;
  logic                req_vld;
  logic                req_rdy;
  logic [PHY_ID_W-1:0] req_phy_id;
  logic                req_int;
  logic                req_fp;
  logic [OFF_W-1:0]    req_off;
  logic [1:0]          req_size;
  logic                req_signed;
  logic                mem_vld;
  logic [DATA_W-1:0]   mem_data;
  logic                cancel_en;
  logic                resp_vld;
  logic                resp_rdy;
  logic [DATA_W-1:0]   resp_data;
  logic [PHY_ID_W-1:0] resp_phy_id;
  logic                fwd_int_en;
  logic                fwd_fp_en;
  logic [PHY_ID_W-1:0] fwd_phy_id;

  toy_dtcm_resp_queue #(
    .DATA_W  (DATA_W),
    .PHY_ID_W(PHY_ID_W),
    .DEPTH   (DEPTH),
    .OFF_W   (OFF_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_vld    (req_vld),
    .req_rdy    (req_rdy),
    .req_phy_id (req_phy_id),
    .req_int    (req_int),
    .req_fp     (req_fp),
    .req_off    (req_off),
    .req_size   (req_size),
    .req_signed (req_signed),
    .mem_vld    (mem_vld),
    .mem_data   (mem_data),
    .cancel_en  (cancel_en),
    .resp_vld   (resp_vld),
    .resp_rdy   (resp_rdy),
    .resp_data  (resp_data),
    .resp_phy_id(resp_phy_id),
    .fwd_int_en (fwd_int_en),
    .fwd_fp_en  (fwd_fp_en),
    .fwd_phy_id (fwd_phy_id)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DATA_W-1:0]   data;
    logic [PHY_ID_W-1:0] id;
    logic                is_int;
    logic                is_fp;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_acc   = 0;

  // Driver-side record of the load whose SRAM data is due this cycle
  logic                pend_m   = 1'b0;
  logic                cur_pend = 1'b0;
  logic [PHY_ID_W-1:0] p_id;
  logic                p_int, p_fp, p_sg;
  logic [OFF_W-1:0]    p_off;
  logic [1:0]          p_sz;
  logic [DATA_W-1:0]   p_mem;

  // Reference load result: byte shift, then keep 8*2^size bits and extend
  function automatic logic [DATA_W-1:0] ref_load(input logic [DATA_W-1:0] raw,
                                                 input int off, input int sz,
                                                 input logic sg);
    logic [DATA_W-1:0] v;
    v = raw >> (off * 8);
`ifdef TOY_DTCM_RESP_SEXT_EN
    if (sz != 3) begin
      int   nb;
      logic s;
      nb = 8 * (2 ** sz);
      s  = sg & v[nb-1];
      for (int b = nb; b < DATA_W; b++) v[b] = s;
    end
`else
    begin
      logic unused_args;
      unused_args = sg ^ (sz != 0);
    end
`endif
    return v;
  endfunction

  task automatic check(input string name, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endtask

  // One clock cycle of stimulus: return SRAM data for the previous accept,
  // and present a new request.
  task automatic step(input logic rv, input logic [PHY_ID_W-1:0] id,
                      input logic it, input logic fp, input logic [OFF_W-1:0] off,
                      input logic [1:0] sz, input logic sg,
                      input logic [DATA_W-1:0] md, input logic cn,
                      input logic rr);
    exp_t e;
    @(posedge clk);
    #1;
    cancel_en = cn;
    resp_rdy  = rr;
    if (pend_m) begin
      mem_vld  = 1'b1;
      mem_data = p_mem;
      if (!cn) begin
        e.data   = ref_load(p_mem, int'(p_off), int'(p_sz), p_sg);
        e.id     = p_id;
        e.is_int = p_int;
        e.is_fp  = p_fp;
        exp_q.push_back(e);
      end
    end else begin
      // Stray return data with nothing pending must be ignored
      mem_vld  = ($urandom_range(0, 3) == 0);
      mem_data = {$urandom, $urandom};
    end
    cur_pend = pend_m & ~cn;
    if (cn) exp_q.delete();
    req_vld    = rv;
    req_phy_id = id;
    req_int    = it;
    req_fp     = fp;
    req_off    = off;
    req_size   = sz;
    req_signed = sg;
    pend_m     = rv & req_rdy & ~cn;
    if (pend_m) begin
      n_acc++;
      p_id  = id;  p_int = it; p_fp = fp;
      p_off = off; p_sz  = sz; p_sg = sg; p_mem = md;
    end
  endtask

  task automatic idle(input logic rr, input logic cn);
    step(1'b0, '0, 1'b0, 1'b0, '0, 2'd0, 1'b0, '0, cn, rr);
  endtask

  // Monitor: compare DUT state against the scoreboard every cycle
  always @(negedge clk) begin
    int   fifo_m;
    exp_t e;
    if (!rst && !cancel_en) begin
      fifo_m = exp_q.size() - int'(cur_pend);
      check("req_rdy", 64'(req_rdy), 64'(exp_q.size() < DEPTH));
      check("resp_vld", 64'(resp_vld), 64'(fifo_m > 0));
      if (resp_vld && resp_rdy && fifo_m > 0) begin
        e = exp_q.pop_front();
        check("resp_data", resp_data, e.data);
        check("resp_phy_id", 64'(resp_phy_id), 64'(e.id));
        check("fwd_phy_id", 64'(fwd_phy_id), 64'(e.id));
        check("fwd_int_en", 64'(fwd_int_en), 64'(e.is_int));
        check("fwd_fp_en", 64'(fwd_fp_en), 64'(e.is_fp));
      end else begin
        check("fwd_int_idle", 64'(fwd_int_en), 64'd0);
        check("fwd_fp_idle", 64'(fwd_fp_en), 64'd0);
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_rdy"}, 64'(req_rdy), 64'd1);
    check({tag, "_resp_vld"}, 64'(resp_vld), 64'd0);
    check({tag, "_fwd_int"}, 64'(fwd_int_en), 64'd0);
    check({tag, "_fwd_fp"}, 64'(fwd_fp_en), 64'd0);
    check({tag, "_resp_data"}, resp_data, 64'd0);
    check({tag, "_resp_id"}, 64'(resp_phy_id), 64'd0);
    check({tag, "_fwd_id"}, 64'(fwd_phy_id), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [DATA_W-1:0] exp_v;
    rst = 1'b1;
    req_vld = 0; req_phy_id = 0; req_int = 0; req_fp = 0; req_off = 0;
    req_size = 0; req_signed = 0; mem_vld = 0; mem_data = 0;
    cancel_en = 0; resp_rdy = 1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("por");
    @(posedge clk);
    #2 rst = 1'b0;

    // Signed byte at offset 3, wakeup to int file id 0x15
    step(1'b1, 6'h15, 1'b1, 1'b0, 3'd3, 2'd0, 1'b1, 64'h0000_0000_8000_0000, 1'b0, 1'b1);
    idle(1'b1, 1'b0);
    idle(1'b1, 1'b0);
    @(negedge clk);
`ifdef TOY_DTCM_RESP_SEXT_EN
    exp_v = 64'hFFFF_FFFF_FFFF_FF80;
`else
    exp_v = 64'h0000_0000_0000_0080;
`endif
    check("sbyte_vld_T2", 64'(resp_vld), 64'd1);
    check("sbyte_data", resp_data, exp_v);
    check("sbyte_fwd_int", 64'(fwd_int_en), 64'd1);
    check("sbyte_fwd_id", 64'(fwd_phy_id), 64'h15);

    // Unsigned half at offset 6, fp destination
    step(1'b1, 6'h2A, 1'b0, 1'b1, 3'd6, 2'd1, 1'b0, 64'hBEEF_0000_0000_0000, 1'b0, 1'b1);
    idle(1'b1, 1'b0);
    idle(1'b1, 1'b0);
    @(negedge clk);
    check("uhalf_data", resp_data, 64'h0000_0000_0000_BEEF);
    check("uhalf_fwd_fp", 64'(fwd_fp_en), 64'd1);

    // Signed byte at offset 0 with 0x80
    step(1'b1, 6'h01, 1'b1, 1'b0, 3'd0, 2'd0, 1'b1, 64'h80, 1'b0, 1'b1);
    idle(1'b1, 1'b0);
    idle(1'b1, 1'b0);
    @(negedge clk);
`ifdef TOY_DTCM_RESP_SEXT_EN
    exp_v = 64'hFFFF_FFFF_FFFF_FF80;
`else
    exp_v = 64'h80;
`endif
    check("byte80_data", resp_data, exp_v);

    // Backpressure: five back-to-back requests, only DEPTH accepted
    n_acc = 0;
    for (int i = 0; i < 5; i++)
      step(1'b1, 6'(i + 8), 1'b1, 1'b0, 3'(i), 2'd3, 1'b0, {$urandom, $urandom}, 1'b0, 1'b0);
    @(negedge clk);
    check("bp_accepts", 64'(n_acc), 64'(DEPTH));
    check("bp_req_rdy_low", 64'(req_rdy), 64'd0);
    idle(1'b0, 1'b0);
    idle(1'b0, 1'b0);
    repeat (8) idle(1'b1, 1'b0);
    @(negedge clk);
    check("bp_drained", 64'(exp_q.size()), 64'd0);
    check("bp_req_rdy_back", 64'(req_rdy), 64'd1);

    // Cancel with two buffered, one pending and its data returning
    step(1'b1, 6'h31, 1'b1, 1'b0, 3'd0, 2'd2, 1'b0, 64'h1111, 1'b0, 1'b0);
    step(1'b1, 6'h32, 1'b0, 1'b1, 3'd0, 2'd2, 1'b0, 64'h2222, 1'b0, 1'b0);
    step(1'b1, 6'h33, 1'b1, 1'b0, 3'd0, 2'd2, 1'b0, 64'h3333, 1'b0, 1'b0);
    step(1'b1, 6'h34, 1'b1, 1'b0, 3'd0, 2'd2, 1'b0, 64'h4444, 1'b1, 1'b1);
    idle(1'b1, 1'b0);
    @(negedge clk);
    check("cancel_resp_vld", 64'(resp_vld), 64'd0);
    check("cancel_req_rdy", 64'(req_rdy), 64'd1);
    check("cancel_fwd_int", 64'(fwd_int_en), 64'd0);
    repeat (4) idle(1'b1, 1'b0);

    // Reset while full
    for (int i = 0; i < 5; i++)
      step(1'b1, 6'(i + 16), 1'b0, 1'b1, 3'd0, 2'd3, 1'b0, {$urandom, $urandom}, 1'b0, 1'b0);
    @(negedge clk);
    check("full_req_rdy_low", 64'(req_rdy), 64'd0);
    rst = 1'b1;
    req_vld = 0; mem_vld = 0; cancel_en = 0; resp_rdy = 1;
    exp_q.delete();
    pend_m = 0; cur_pend = 0;
    #1;
    check_reset_outputs("mid");
    @(posedge clk);
    #2 rst = 1'b0;
    step(1'b1, 6'h3F, 1'b1, 1'b0, 3'd7, 2'd0, 1'b0, 64'hAB00_0000_0000_0000, 1'b0, 1'b1);
    idle(1'b1, 1'b0);
    idle(1'b1, 1'b0);
    @(negedge clk);
    check("post_rst_data", resp_data, 64'hAB);
    check("post_rst_id", 64'(resp_phy_id), 64'h3F);

    // Randomized traffic
    for (int c = 0; c < 2000; c++) begin
      logic [1:0] dst;
      dst = 2'($urandom_range(0, 2));
      step($urandom_range(0, 3) != 0, 6'($urandom), dst == 2'd1, dst == 2'd2,
           3'($urandom), 2'($urandom), 1'($urandom), {$urandom, $urandom},
           $urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0);
    end
    repeat (10) idle(1'b1, 1'b0);
    @(negedge clk);
    check("final_drained", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/toy_dtcm_resp_queue.md
# toy_dtcm_resp_queue

Parametrised DTCM load-response tracker for the LSU, sitting between the DTCM request port and the load writeback/wakeup path. It accepts load requests with their sideband, captures the SRAM read data returned one cycle later, and aligns and extends that data by byte offset and size. Results are buffered in a DEPTH-entry FIFO so writeback can backpressure. It flushes all in-flight and buffered loads on `cancel_en`, and raises the int/fp forward wakeup only on the cycle a result actually leaves.

## Interface
- `DATA_W`, 64, load data width in bits (power of two, ≥32).
- `PHY_ID_W`, 6, physical register id width.
- `DEPTH`, 4, response FIFO entries (power of two, ≥2); also the maximum number of loads tracked.
- `OFF_W`, $clog2(DATA_W/8), byte-offset width (derived).
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `req_vld`  in  1  load request to DTCM.
- `req_rdy`  out  1  tracker can accept a request.
- `req_phy_id`  in  PHY_ID_W  destination physical register.
- `req_int`, `req_fp`  in  1 each  destination is int / fp file (one-hot or both 0).
- `req_off`  in  OFF_W  byte offset within the data word.
- `req_size`  in  2  0=byte, 1=half, 2=word, 3=double.
- `req_signed`  in  1  sign-extend result.
- `mem_vld`  in  1  SRAM read data valid.
- `mem_data`  in  DATA_W  raw SRAM read word.
- `cancel_en`  in  1  pipeline flush.
- `resp_vld`  out  1  aligned result available.
- `resp_rdy`  in  1  writeback accepts the result.
- `resp_data`  out  DATA_W  aligned/extended result.
- `resp_phy_id`  out  PHY_ID_W  destination of the head result.
- `fwd_int_en`, `fwd_fp_en`  out  1 each  wakeup for the int / fp file.
- `fwd_phy_id`  out  PHY_ID_W  wakeup register id (= `resp_phy_id`).

## Operation
- Accept: `req_vld & req_rdy`. Sideband goes to a single pending stage (`pend_vld`, id, int, fp, off, size, signed).
- Credit: `req_rdy = (pend_vld + fifo_cnt) < DEPTH`. Count width is $clog2(DEPTH)+1.
- Return: `mem_vld` is expected in the cycle after acceptance. If `mem_vld & pend_vld & ~cancel_en`, the entry is pushed with aligned data and `pend_vld` is cleared unless a new request is accepted in the same cycle. `mem_vld` without `pend_vld` is ignored.
- Alignment: `aligned = mem_data >> (off*8)`.
- Extension: the low 8<<size bits are kept. The upper bits are filled with the MSB of the kept field if signed, else with 0. Size 3 is passed through unchanged.
- Pop: `resp_vld & resp_rdy`. A push and a pop in the same cycle leave `fifo_cnt` unchanged. Pointers wrap modulo DEPTH.
- Forward: `fwd_int_en = resp_vld & resp_rdy & head.int`. `fwd_fp_en` is the same using `head.fp`. Both are combinational from the FIFO head.
- Cancel: `cancel_en` clears `pend_vld`, the FIFO (pointers and count), and any same-cycle accept or push. `req_rdy` stays combinational and is not gated by cancel. A request accepted during cancel is discarded. In the cancel cycle, `resp_vld` and `fwd_*` are still driven from the pre-cancel state; the tracker treats a pop in that cycle as void and writeback must ignore it.
- Reset (`rst` high, any time): pend and FIFO are cleared. Outputs: `req_rdy`=1, `resp_vld`=0, `fwd_int_en`=`fwd_fp_en`=0, `resp_data`/`resp_phy_id`/`fwd_phy_id`=0. FIFO data storage is not reset; its outputs are masked to 0 when empty.

## Timing
- Request accepted at T, `mem_vld` at T+1, `resp_vld` at T+2. Load-to-writeback latency is 2 cycles with no backpressure.
- Sustained throughput is 1 load/cycle with `resp_rdy` held high.
- Full: when `pend_vld + fifo_cnt == DEPTH`, `req_rdy` is low. It rises in the cycle after a pop frees a slot; it is registered-state based and has no combinational path from `resp_rdy`.
- Empty: `resp_vld` is 0. Push-to-output latency is 1 cycle; the FIFO has no bypass.

## Configuration
- `TOY_DTCM_RESP_SEXT_EN` defined: size/sign extension is applied as described above.
- Undefined: `resp_data = mem_data >> (off*8)` only. `req_size` and `req_signed` are ignored, and the caller masks and extends.

## Test plan
- Single signed byte: `off`=3, size=0, signed=1, `mem_data`=0x0000_0000_8000_0000 → `resp_data`=0xFFFF_FFFF_FFFF_FF80 at T+2, `fwd_int_en`=1 with `phy_id`=0x15 on the pop.
- Unsigned half: `off`=6, size=1, `mem_data`=0xBEEF_0000_0000_0000 → 0x0000_0000_0000_BEEF.
- Backpressure: `resp_rdy`=0, 5 back-to-back requests with DEPTH=4 → 4 accepted, `req_rdy`=0. Release → results pop in order and `req_rdy` returns.
- Cancel mid-flight: 2 results buffered, 1 pending, `cancel_en` with `mem_vld` → cycle after: `resp_vld`=0, count 0, `req_rdy`=1, and no `fwd_*` pulse thereafter.
- Reset while the FIFO is full → all outputs take their reset values immediately and the next request behaves as if the tracker were empty.
- Macro off: size=0, signed=1, `off`=0, `mem_data`=0x80 → `resp_data`=0x80 (no extension).
